timer_ctrl: RTL and testbench

//   Sequencing controller for the MM:SS countdown timer of the watch.
//   - Accepts button inputs and lets the user set a preset.
//   - Runs, pauses and resumes the countdown from a 1 s tick derived internally from clk100MHz.
//   - Raises a timed alarm when the count reaches 00:00.
//   - Drives the four BCD digits to the display mux.

---
 rtl/timer_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_timer_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_ctrl.sv
// MM:SS countdown timer controller.
// Button edges set a preset, start/pause/resume the countdown from an internal
// 1 s tick, and a timed alarm is raised when the count reaches 00:00.
module timer_ctrl #(
    parameter int unsigned TICK_DIV   = 100_000_000,
    parameter int unsigned ALARM_SECS = 10
) (
    input  logic       clk100MHz,
    input  logic       reset,
    input  logic       start,
    input  logic       clear,
    input  logic       secbtn,
    input  logic       tensecbtn,
    input  logic       minbtn,
    output logic [3:0] tenminout,
    output logic [3:0] oneminout,
    output logic [3:0] tensecout,
    output logic [3:0] onesecout,
    output logic       running,
    output logic       alarm
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned AW = (ALARM_SECS > 1) ? $clog2(ALARM_SECS + 1) : 1;
    localparam logic [PW-1:0] PRESC_MAX  = PW'(TICK_DIV - 1);
    localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_SECS - 1);

    typedef enum logic [1:0] {StSet, StRun, StPause, StAlarm} state_t;

    state_t        r_state;
    logic [PW-1:0] r_presc;
    logic [AW-1:0] r_alarm_cnt;
    logic [3:0]    r_tenmin, r_onemin, r_tensec, r_onesec;
    logic          r_running, r_alarm;
    logic          r_prev_start, r_prev_clear, r_prev_sec, r_prev_tensec, r_prev_min;

    logic          w_start_edge, w_clear_edge, w_sec_edge, w_tensec_edge, w_min_edge;
    logic          w_tick, w_nonzero, w_dec_zero;
    logic [3:0]    w_dec_tenmin, w_dec_onemin, w_dec_tensec, w_dec_onesec;
    logic [3:0]    w_inc_tenmin, w_inc_onemin, w_inc_tensec, w_inc_onesec;

    assign w_start_edge  = start & ~r_prev_start;
    assign w_clear_edge  = clear & ~r_prev_clear;
    assign w_sec_edge    = secbtn & ~r_prev_sec;
    assign w_tensec_edge = tensecbtn & ~r_prev_tensec;
    assign w_min_edge    = minbtn & ~r_prev_min;

    assign w_tick    = ((r_state == StRun) || (r_state == StAlarm)) && (r_presc == PRESC_MAX);
    assign w_nonzero = |{r_tenmin, r_onemin, r_tensec, r_onesec};

    // Previous button levels; reset loads the live level so a held button gives no edge
    always_ff @(posedge clk100MHz) begin
        r_prev_start  <= start;
        r_prev_clear  <= clear;
        r_prev_sec    <= secbtn;
        r_prev_tensec <= tensecbtn;
        r_prev_min    <= minbtn;
    end

    // BCD decrement of MM:SS with borrow; only used when the count is nonzero
    always_comb begin
        w_dec_tenmin = r_tenmin;
        w_dec_onemin = r_onemin;
        w_dec_tensec = r_tensec;
        w_dec_onesec = r_onesec;
        if (r_onesec != 4'd0) begin
            w_dec_onesec = r_onesec - 4'd1;
        end else begin
            w_dec_onesec = 4'd9;
            if (r_tensec != 4'd0) begin
                w_dec_tensec = r_tensec - 4'd1;
            end else begin
                w_dec_tensec = 4'd5;
                if (r_onemin != 4'd0) begin
                    w_dec_onemin = r_onemin - 4'd1;
                end else begin
                    w_dec_onemin = 4'd9;
                    w_dec_tenmin = r_tenmin - 4'd1;
                end
            end
        end
        w_dec_zero = ~|{w_dec_tenmin, w_dec_onemin, w_dec_tensec, w_dec_onesec};
    end

    // Preset digit increments; simultaneous button edges all apply together
    always_comb begin
        w_inc_tenmin = r_tenmin;
        w_inc_onemin = r_onemin;
        w_inc_tensec = r_tensec;
        w_inc_onesec = r_onesec;
        if (w_sec_edge) begin
            w_inc_onesec = (r_onesec == 4'd9) ? 4'd0 : r_onesec + 4'd1;
        end
        if (w_tensec_edge) begin
            w_inc_tensec = (r_tensec == 4'd5) ? 4'd0 : r_tensec + 4'd1;
        end
        if (w_min_edge) begin
            if (r_onemin == 4'd9) begin
                w_inc_onemin = 4'd0;
                w_inc_tenmin = (r_tenmin == 4'd9) ? 4'd0 : r_tenmin + 4'd1;
            end else begin
                w_inc_onemin = r_onemin + 4'd1;
            end
        end
    end

    // Main FSM with prescaler, alarm counter, digits and registered status outputs
    always_ff @(posedge clk100MHz) begin
        if (reset) begin
            r_state     <= StSet;
            r_presc     <= '0;
            r_alarm_cnt <= '0;
            r_tenmin    <= 4'd0;
            r_onemin    <= 4'd0;
            r_tensec    <= 4'd0;
            r_onesec    <= 4'd0;
            r_running   <= 1'b0;
            r_alarm     <= 1'b0;
        end else begin
            // Free-run in RUN/ALARM, parked at zero elsewhere; entries override to zero
            if ((r_state == StRun) || (r_state == StAlarm)) begin
                r_presc <= w_tick ? '0 : r_presc + 1'b1;
            end else begin
                r_presc <= '0;
            end

            if (w_clear_edge) begin
                r_state   <= StSet;
                r_tenmin  <= 4'd0;
                r_onemin  <= 4'd0;
                r_tensec  <= 4'd0;
                r_onesec  <= 4'd0;
                r_running <= 1'b0;
                r_alarm   <= 1'b0;
            end else begin
                case (r_state)
                    StSet: begin
                        if (w_start_edge) begin
                            // Starting from 00:00 is ignored
                            if (w_nonzero) begin
                                r_state   <= StRun;
                                r_running <= 1'b1;
                                r_presc   <= '0;
                            end
                        end else begin
                            r_tenmin <= w_inc_tenmin;
                            r_onemin <= w_inc_onemin;
                            r_tensec <= w_inc_tensec;
                            r_onesec <= w_inc_onesec;
                        end
                    end
                    StRun: begin
                        if (w_start_edge) begin
                            r_state   <= StPause;
                            r_running <= 1'b0;
                        end else if (w_tick) begin
                            r_tenmin <= w_dec_tenmin;
                            r_onemin <= w_dec_onemin;
                            r_tensec <= w_dec_tensec;
                            r_onesec <= w_dec_onesec;
                            if (w_dec_zero) begin
                                r_state     <= StAlarm;
                                r_running   <= 1'b0;
                                r_alarm     <= 1'b1;
                                r_presc     <= '0;
                                r_alarm_cnt <= '0;
                            end
                        end
                    end
                    StPause: begin
                        if (w_start_edge) begin
                            r_state   <= StRun;
                            r_running <= 1'b1;
                            r_presc   <= '0;
                        end
                    end
                    StAlarm: begin
                        if (w_start_edge) begin
                            r_state <= StSet;
                            r_alarm <= 1'b0;
                        end else if (w_tick) begin
                            if (r_alarm_cnt == ALARM_LAST) begin
                                r_state <= StSet;
                                r_alarm <= 1'b0;
                            end else begin
                                r_alarm_cnt <= r_alarm_cnt + 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_state   <= StSet;
                        r_running <= 1'b0;
                        r_alarm   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign tenminout = r_tenmin;
    assign oneminout = r_onemin;
    assign tensecout = r_tensec;
    assign onesecout = r_onesec;
    assign running   = r_running;
    assign alarm     = r_alarm;

endmodule

// File: tb/tb_timer_ctrl.sv
// Testbench for timer_ctrl: directed scenarios plus randomized button activity,
// checked every cycle against a seconds-based reference model via a scoreboard.
module tb_timer_ctrl;

    localparam int unsigned TICK_DIV   = 4;
    localparam int unsigned ALARM_SECS = 2;

    localparam int MS_SET   = 0;
    localparam int MS_RUN   = 1;
    localparam int MS_PAUSE = 2;
    localparam int MS_ALARM = 3;

    logic       clk100MHz = 1'b0;
    logic       reset     = 1'b1;
    logic       start     = 1'b0;
    logic       clear     = 1'b0;
    logic       secbtn    = 1'b0;
    logic       tensecbtn = 1'b0;
    logic       minbtn    = 1'b0;
    logic [3:0] tenminout, oneminout, tensecout, onesecout;
    logic       running, alarm;

    always #5 clk100MHz = ~clk100MHz;

    timer_ctrl #(
        .TICK_DIV   (TICK_DIV),
        .ALARM_SECS (ALARM_SECS)
    ) dut (
        .clk100MHz (clk100MHz),
        .reset     (reset),
        .start     (start),
        .clear     (clear),
        .secbtn    (secbtn),
        .tensecbtn (tensecbtn),
        .minbtn    (minbtn),
        .tenminout (tenminout),
        .oneminout (oneminout),
        .tensecout (tensecout),
        .onesecout (onesecout),
        .running   (running),
        .alarm     (alarm)
    );

    typedef struct {
        logic [17:0] model;
        bit          has_spec;
        logic [17:0] spec;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   done     = 1'b0;

    // Reference model: count held as total seconds, state as plain integer
    int       m_state = MS_SET;
    int       m_secs  = 0;
    int       m_entry = 0;
    int       m_aticks = 0;
    int       cyc = 0;
    bit [4:0] m_prev = '0;

    function automatic logic [17:0] model_out();
        int mm;
        int ss;
        mm = m_secs / 60;
        ss = m_secs % 60;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10),
                (m_state == MS_RUN), (m_state == MS_ALARM)};
    endfunction

    // b = {start, clear, sec, tensec, min}
    task automatic model_edge(input bit rst, input bit [4:0] b);
        bit [4:0] e;
        bit       tick;
        int       mm;
        int       ss;
        cyc++;
        if (rst) begin
            m_state = MS_SET;
            m_secs  = 0;
            m_prev  = b;
            return;
        end
        e      = b & ~m_prev;
        m_prev = b;
        tick   = ((m_state == MS_RUN) || (m_state == MS_ALARM)) &&
                 (((cyc - m_entry) % TICK_DIV) == 0);
        if (e[3]) begin
            m_state = MS_SET;
            m_secs  = 0;
        end else begin
            case (m_state)
                MS_SET: begin
                    if (e[4]) begin
                        if (m_secs != 0) begin
                            m_state = MS_RUN;
                            m_entry = cyc;
                        end
                    end else begin
                        mm = m_secs / 60;
                        ss = m_secs % 60;
                        if (e[2]) ss = (ss / 10) * 10 + ((ss % 10) + 1) % 10;
                        if (e[1]) ss = (((ss / 10) + 1) % 6) * 10 + ss % 10;
                        if (e[0]) mm = (mm + 1) % 100;
                        m_secs = mm * 60 + ss;
                    end
                end
                MS_RUN: begin
                    if (e[4]) begin
                        m_state = MS_PAUSE;
                    end else if (tick) begin
                        m_secs = m_secs - 1;
                        if (m_secs == 0) begin
                            m_state  = MS_ALARM;
                            m_entry  = cyc;
                            m_aticks = 0;
                        end
                    end
                end
                MS_PAUSE: begin
                    if (e[4]) begin
                        m_state = MS_RUN;
                        m_entry = cyc;
                    end
                end
                default: begin
                    if (e[4]) begin
                        m_state = MS_SET;
                    end else if (tick) begin
                        m_aticks++;
                        if (m_aticks == ALARM_SECS) m_state = MS_SET;
                    end
                end
            endcase
        end
    endtask

    // Drive one cycle of inputs and queue the expected post-edge outputs
    task automatic step(input bit rst, input bit [4:0] b);
        exp_t e;
        @(negedge clk100MHz);
        reset     = rst;
        start     = b[4];
        clear     = b[3];
        secbtn    = b[2];
        tensecbtn = b[1];
        minbtn    = b[0];
        model_edge(rst, b);
        e.model    = model_out();
        e.has_spec = 1'b0;
        e.spec     = '0;
        e.name     = "";
        sb_q.push_back(e);
    endtask

    task automatic press(input bit [4:0] b);
        step(1'b0, b);
        step(1'b0, 5'b00000);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 5'b00000);
    endtask

    // Attach a hand-derived expectation to the most recently issued cycle
    task automatic spec_expect(input string name, input logic [15:0] digits,
                               input bit run, input bit alm);
        exp_t e;
        e          = sb_q.pop_back();
        e.has_spec = 1'b1;
        e.spec     = {digits, run, alm};
        e.name     = name;
        sb_q.push_back(e);
    endtask

    // Monitor: pops one expectation per clock and compares the DUT outputs
    initial begin
        exp_t        e;
        logic [17:0] got;
        forever begin
            @(posedge clk100MHz);
            #1;
            got = {tenminout, oneminout, tensecout, onesecout, running, alarm};
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                n_checks++;
                if (got !== e.model) begin
                    n_fail++;
                    $display("FAIL scoreboard t=%0t got %h expected %h", $time, got, e.model);
                end
                if (e.has_spec) begin
                    n_checks++;
                    if (got !== e.spec) begin
                        n_fail++;
                        $display("FAIL %s t=%0t got %h expected %h", e.name, $time, got, e.spec);
                    end
                end
            end else if (done) begin
                $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
                $finish;
            end
        end
    end

    initial begin
        logic [4:0] lv;
        bit         r;

        // Reset
        step(1'b1, 5'b00000);
        step(1'b1, 5'b00000);
        spec_expect("reset", 16'h0000, 1'b0, 1'b0);

        // Preset entry
        repeat (3) press(5'b00100);
        press(5'b00010);
        repeat (2) press(5'b00001);
        spec_expect("preset_0213", 16'h0213, 1'b0, 1'b0);

        // Countdown to alarm from 00:02
        press(5'b01000);
        repeat (2) press(5'b00100);
        step(1'b0, 5'b10000);
        spec_expect("run_enter", 16'h0002, 1'b1, 1'b0);
        idle(3);
        spec_expect("before_tick", 16'h0002, 1'b1, 1'b0);
        idle(1);
        spec_expect("first_tick", 16'h0001, 1'b1, 1'b0);
        idle(4);
        spec_expect("alarm_on", 16'h0000, 1'b0, 1'b1);
        idle(7);
        spec_expect("alarm_hold", 16'h0000, 1'b0, 1'b1);
        idle(1);
        spec_expect("alarm_off", 16'h0000, 1'b0, 1'b0);

        // Borrow across all digits
        press(5'b01000);
        repeat (10) press(5'b00001);
        step(1'b0, 5'b10000);
        idle(4);
        spec_expect("borrow_0959", 16'h0959, 1'b1, 1'b0);

        // Wrap of preset digits
        press(5'b01000);
        repeat (100) press(5'b00001);
        spec_expect("min_wrap", 16'h0000, 1'b0, 1'b0);
        repeat (10) press(5'b00100);
        repeat (6) press(5'b00010);
        spec_expect("sec_wrap", 16'h0000, 1'b0, 1'b0);

        // Pause, resume, clear
        repeat (5) press(5'b00001);
        step(1'b0, 5'b10000);
        idle(8);
        spec_expect("two_ticks", 16'h0458, 1'b1, 1'b0);
        step(1'b0, 5'b00000);
        step(1'b0, 5'b10000);
        idle(20);
        spec_expect("paused_hold", 16'h0458, 1'b0, 1'b0);
        step(1'b0, 5'b10000);
        spec_expect("resume", 16'h0458, 1'b1, 1'b0);
        idle(1);
        step(1'b0, 5'b01000);
        spec_expect("clear_run", 16'h0000, 1'b0, 1'b0);
        idle(1);

        // Start at 00:00 ignored
        press(5'b10000);
        spec_expect("start_zero", 16'h0000, 1'b0, 1'b0);

        // minbtn held across reset release
        step(1'b1, 5'b00001);
        step(1'b1, 5'b00001);
        step(1'b0, 5'b00001);
        step(1'b0, 5'b00001);
        spec_expect("held_reset", 16'h0000, 1'b0, 1'b0);
        idle(1);

        // Randomized segments: small preset, start, then random button activity
        for (int s = 0; s < 40; s++) begin
            press(5'b01000);
            repeat ($urandom_range(1, 4)) press(5'b00100);
            if ($urandom_range(0, 1) == 1) press(5'b00010);
            if ($urandom_range(0, 5) == 0) press(5'b00001);
            press(5'b10000);
            lv = '0;
            for (int c = 0; c < 70; c++) begin
                if ($urandom_range(0, 29) == 0)  lv[4] = ~lv[4];
                if ($urandom_range(0, 299) == 0) lv[3] = ~lv[3];
                if ($urandom_range(0, 9) == 0)   lv[2] = ~lv[2];
                if ($urandom_range(0, 9) == 0)   lv[1] = ~lv[1];
                if ($urandom_range(0, 11) == 0)  lv[0] = ~lv[0];
                r = ($urandom_range(0, 599) == 0);
                step(r, lv);
            end
            step(1'b0, 5'b00000);
        end

        done = 1'b1;
        repeat (20) @(posedge clk100MHz);
        $display("FAIL watchdog scoreboard did not drain, %0d entries left, expected 0", sb_q.size());
        $fatal(1);
    end

endmodule
